bash_f_core: RTL and testbench

Iterative Bash-F sponge permutation engine (STB 34.101.77) with a parametrised number of Bash-S instances per cycle, trading area against latency. Sits between the AXI4-Lite register front-end and the Bash-Hash sponge controller. Takes a 1536-bit state, applies ROUNDS rounds, and returns the permuted state with a one-cycle done pulse. All constants come from `bash_hash_params_pkg`: M1/N1/M2/N2_BASH_S, BASH_F_INIT and BASH_F_CONST.

---
 rtl/bash_f_core.sv | 188 ++++++++++++++++++
 tb/tb_bash_f_core.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bash_f_core.sv
// bash_f_core -- iterative Bash-F sponge permutation (STB 34.101.77).
//
// S_PER_CYC Bash-S column lanes run per cycle, so one round takes
// G = 8/S_PER_CYC cycles. The last group of each round also applies the
// word permutation and folds in the round constant.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous active-high reset
//   start    job request, accepted when ready=1
//   state_i  1536-bit input state, word k = state_i[64k+63:64k]
//   ready    engine idle, start will be accepted
//   done     one-cycle pulse, state_o valid
//   state_o  permuted state, held until the next accepted start

package bash_hash_params_pkg;
    // Rotation amounts for columns j=7..0 (index j selects column j).
    localparam logic [7:0][5:0] M1_BASH_S = {6'd56, 6'd8, 6'd56, 6'd8, 6'd56, 6'd8, 6'd56, 6'd8};
    localparam logic [7:0][5:0] N1_BASH_S = {6'd35, 6'd5, 6'd19, 6'd21, 6'd3, 6'd37, 6'd51, 6'd53};
    localparam logic [7:0][5:0] M2_BASH_S = {6'd2, 6'd46, 6'd34, 6'd14, 6'd2, 6'd46, 6'd34, 6'd14};
    localparam logic [7:0][5:0] N2_BASH_S = {6'd55, 6'd17, 6'd39, 6'd33, 6'd23, 6'd49, 6'd7, 6'd1};
    localparam logic [63:0] BASH_F_INIT  = 64'hB194BAC80A08F53B;
    localparam logic [63:0] BASH_F_CONST = 64'hAED8E07F99E12BDC;
endpackage

// One Bash-S column. Rotation amounts are inputs because a lane serves a
// different column in each group when S_PER_CYC < 8.
module bash_s_lane (
    input  logic [63:0] w0,
    input  logic [63:0] w1,
    input  logic [63:0] w2,
    input  logic [5:0]  m1,
    input  logic [5:0]  n1,
    input  logic [5:0]  m2,
    input  logic [5:0]  n2,
    output logic [63:0] r0,
    output logic [63:0] r1,
    output logic [63:0] r2
);
    function automatic logic [63:0] rotl(input logic [63:0] x, input logic [5:0] k);
        logic [127:0] d;
        d = {x, x} << k;
        return d[127:64];
    endfunction

    logic [63:0] t0a, t1a, x0, x1, x2;

    always_comb begin
        t0a = rotl(w1, m1);
        x0  = w0 ^ w1 ^ w2;
        t1a = w1 ^ rotl(x0, n1);
        x1  = t0a ^ t1a;
        x2  = w2 ^ rotl(w2, m2) ^ rotl(t1a, n2);
        r0  = x0 ^ (~x2 | x1);
        r1  = x1 ^ (x0 | x2);
        r2  = x2 ^ (x0 & x1);
    end
endmodule

module bash_f_core
    import bash_hash_params_pkg::*;
#(
    parameter int S_PER_CYC = 2,
    parameter int ROUNDS    = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1535:0] state_i,
    output logic          ready,
    output logic          done,
    output logic [1535:0] state_o
);
    localparam int G  = 8 / S_PER_CYC;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);
    localparam logic [4:0]    RND_LAST = 5'(ROUNDS - 1);
    // New S[k] = S[P_IDX[k]]
    localparam int P_IDX [24] = '{15, 10, 9, 12, 11, 14, 13, 8,
                                  17, 16, 19, 18, 21, 20, 23, 22,
                                  6, 3, 0, 5, 2, 7, 4, 1};

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t                state_q, state_n;
    logic [23:0][63:0]   st, st_n, s_lay, perm;
    logic [63:0]         c, c_n;
    logic [GW-1:0]       grp, grp_n;
    logic [4:0]          rnd, rnd_n;
    logic [1535:0]       so_q, so_n;
    logic                done_q, done_n;

    logic [S_PER_CYC-1:0][2:0]  col;
    logic [S_PER_CYC-1:0][63:0] r0, r1, r2;

    // Lane i works on column j = grp*S_PER_CYC + i; words j, 8+j, 16+j.
    for (genvar i = 0; i < S_PER_CYC; i++) begin : g_lane
        assign col[i] = 3'(int'(grp) * S_PER_CYC + i);
        bash_s_lane u_lane (
            .w0 (st[{2'b00, col[i]}]),
            .w1 (st[{2'b01, col[i]}]),
            .w2 (st[{2'b10, col[i]}]),
            .m1 (M1_BASH_S[col[i]]),
            .n1 (N1_BASH_S[col[i]]),
            .m2 (M2_BASH_S[col[i]]),
            .n2 (N2_BASH_S[col[i]]),
            .r0 (r0[i]),
            .r1 (r1[i]),
            .r2 (r2[i])
        );
    end

    // S-layer written back in place, then P and the constant on top of it.
    always_comb begin
        s_lay = st;
        for (int i = 0; i < S_PER_CYC; i++) begin
            s_lay[{2'b00, col[i]}] = r0[i];
            s_lay[{2'b01, col[i]}] = r1[i];
            s_lay[{2'b10, col[i]}] = r2[i];
        end
        for (int k = 0; k < 24; k++) begin
            perm[k] = s_lay[P_IDX[k]];
        end
        perm[23] = perm[23] ^ c;
    end

    always_comb begin
        state_n = state_q;
        st_n    = st;
        c_n     = c;
        grp_n   = grp;
        rnd_n   = rnd;
        so_n    = so_q;
        done_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    st_n    = state_i;
                    c_n     = BASH_F_INIT;
                    grp_n   = '0;
                    rnd_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (grp == GRP_LAST) begin
                    st_n  = perm;
                    c_n   = {1'b0, c[63:1]} ^ (c[0] ? BASH_F_CONST : 64'd0);
                    grp_n = '0;
                    rnd_n = rnd + 5'd1;
                    if (rnd == RND_LAST) begin
                        so_n    = perm;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    st_n  = s_lay;
                    grp_n = grp + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st      <= '0;
            c       <= '0;
            grp     <= '0;
            rnd     <= '0;
            so_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            st      <= st_n;
            c       <= c_n;
            grp     <= grp_n;
            rnd     <= rnd_n;
            so_q    <= so_n;
            done_q  <= done_n;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = done_q;
    assign state_o = so_q;
endmodule

// File: tb/tb_bash_f_core.sv
// Bench for bash_f_core: six instances (ROUNDS=24 with S_PER_CYC 1/2/4/8,
// ROUNDS=1 with S=8, ROUNDS=2 with S=2) against a whole-round reference model.
module tb_bash_f_core;
    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    start;
    logic [1535:0] state_i;
    logic [5:0]    ready, done;
    logic [1535:0] so [6];

    int total = 0;
    int bad   = 0;

    localparam int LAT  [6] = '{192, 96, 48, 24, 1, 8};
    localparam int RNDS [6] = '{24, 24, 24, 24, 1, 2};
    localparam int TM1 [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
    localparam int TN1 [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
    localparam int TM2 [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
    localparam int TN2 [8] = '{1, 7, 49, 23, 33, 39, 17, 55};
    localparam int PI  [24] = '{15, 10, 9, 12, 11, 14, 13, 8, 17, 16, 19, 18,
                                21, 20, 23, 22, 6, 3, 0, 5, 2, 7, 4, 1};

    always #5 clk = ~clk;

    bash_f_core #(.S_PER_CYC(1), .ROUNDS(24)) u_s1 (.clk(clk), .rst(rst), .start(start[0]),
        .state_i(state_i), .ready(ready[0]), .done(done[0]), .state_o(so[0]));
    bash_f_core #(.S_PER_CYC(2), .ROUNDS(24)) u_s2 (.clk(clk), .rst(rst), .start(start[1]),
        .state_i(state_i), .ready(ready[1]), .done(done[1]), .state_o(so[1]));
    bash_f_core #(.S_PER_CYC(4), .ROUNDS(24)) u_s4 (.clk(clk), .rst(rst), .start(start[2]),
        .state_i(state_i), .ready(ready[2]), .done(done[2]), .state_o(so[2]));
    bash_f_core #(.S_PER_CYC(8), .ROUNDS(24)) u_s8 (.clk(clk), .rst(rst), .start(start[3]),
        .state_i(state_i), .ready(ready[3]), .done(done[3]), .state_o(so[3]));
    bash_f_core #(.S_PER_CYC(8), .ROUNDS(1))  u_r1 (.clk(clk), .rst(rst), .start(start[4]),
        .state_i(state_i), .ready(ready[4]), .done(done[4]), .state_o(so[4]));
    bash_f_core #(.S_PER_CYC(2), .ROUNDS(2))  u_r2 (.clk(clk), .rst(rst), .start(start[5]),
        .state_i(state_i), .ready(ready[5]), .done(done[5]), .state_o(so[5]));

    function automatic logic [63:0] rotl(input logic [63:0] v, input int k);
        return (v << k) | (v >> (64 - k));
    endfunction

    // Whole rounds at once: all eight columns, P, constant, next constant.
    function automatic logic [1535:0] ref_f(input logic [1535:0] x, input int rounds,
                                            output logic [63:0] pre23);
        logic [63:0] s [24];
        logic [63:0] t [24];
        logic [63:0] c, a, b, d, u0, u1, u2;
        logic [1535:0] y;
        c = 64'hB194BAC80A08F53B;
        pre23 = '0;
        for (int k = 0; k < 24; k++) s[k] = x[64*k +: 64];
        for (int r = 0; r < rounds; r++) begin
            for (int j = 0; j < 8; j++) begin
                a = s[j]; b = s[8+j]; d = s[16+j];
                u0 = rotl(b, TM1[j]);
                a  = a ^ b ^ d;
                u1 = b ^ rotl(a, TN1[j]);
                b  = u0 ^ u1;
                d  = d ^ rotl(d, TM2[j]) ^ rotl(u1, TN2[j]);
                u0 = ~d | b; u1 = a | d; u2 = a & b;
                b = b ^ u1; d = d ^ u2; a = a ^ u0;
                s[j] = a; s[8+j] = b; s[16+j] = d;
            end
            for (int k = 0; k < 24; k++) t[k] = s[PI[k]];
            s = t;
            pre23 = s[23];
            s[23] = s[23] ^ c;
            c = c[0] ? ((c >> 1) ^ 64'hAED8E07F99E12BDC) : (c >> 1);
        end
        for (int k = 0; k < 24; k++) y[64*k +: 64] = s[k];
        return y;
    endfunction

    function automatic logic [1535:0] rand_state();
        logic [1535:0] x;
        for (int w = 0; w < 48; w++) x[32*w +: 32] = $urandom;
        return x;
    endfunction

    task automatic chk_vec(input string nm, input logic [1535:0] act, input logic [1535:0] exp);
        int w;
        total++;
        if (act !== exp) begin
            bad++;
            w = 0;
            while (w < 23 && act[64*w +: 64] === exp[64*w +: 64]) w++;
            $display("FAIL %s: word %0d got %h want %h", nm, w, act[64*w +: 64], exp[64*w +: 64]);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    logic [1535:0] res_q [6];
    int            lat_q [6];

    // Pulse start on the masked instances, collect result and latency
    // (cycles from the accepting edge to the edge that raises done).
    task automatic run_jobs(input logic [5:0] mask, input logic [1535:0] s);
        int k;
        logic [5:0] pend;
        for (int d = 0; d < 6; d++) begin lat_q[d] = -1; res_q[d] = '0; end
        @(negedge clk);
        state_i = s;
        start   = mask;
        @(negedge clk);
        start = '0;
        pend  = mask;
        k     = 0;
        while (pend != 0 && k <= 250) begin
            for (int d = 0; d < 6; d++) begin
                if (pend[d] && done[d]) begin
                    lat_q[d] = k; res_q[d] = so[d]; pend[d] = 1'b0;
                end
            end
            if (pend != 0) begin @(negedge clk); k++; end
        end
    endtask

    typedef struct {
        int            dut;
        logic [1535:0] st;
        logic [1535:0] exp;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl [7];
        logic [1535:0] lit, pat, s;
        logic [63:0]   p23;
        int            k, nacc, ndone, extra, sawdone;
        int            acc_k [3];
        logic [1535:0] acc_s [3];
        logic [1535:0] prev;
        logic          stable;

        // Hand-derived ROUNDS=1 result for the all-zero state.
        lit = '0;
        for (int w = 16; w < 23; w++) lit[64*w +: 64] = '1;
        lit[64*23 +: 64] = 64'h4E6B4537F5F70AC4;
        for (int w = 0; w < 24; w++) pat[64*w +: 64] = {56'h0123456789ABCD, 8'(w)};

        tbl[0] = '{4, '0, lit};
        tbl[1].dut = 4; tbl[1].st = rand_state();
        tbl[2].dut = 0; tbl[2].st = '1;
        tbl[3].dut = 1; tbl[3].st = pat;
        tbl[4].dut = 2; tbl[4].st = rand_state();
        tbl[5].dut = 3; tbl[5].st = rand_state();
        tbl[6].dut = 5; tbl[6].st = '0;
        for (int i = 1; i < 7; i++) tbl[i].exp = ref_f(tbl[i].st, RNDS[tbl[i].dut], p23);

        rst = 1'b1; start = '0; state_i = '0;
        repeat (3) @(negedge clk);
        chk64("rst_ready", 64'(ready), 64'h3F);
        chk64("rst_done", 64'(done), 64'h0);
        for (int d = 0; d < 6; d++) chk_vec("rst_state_o", so[d], '0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_jobs(6'(1 << tbl[i].dut), tbl[i].st);
            chk_vec($sformatf("vec%0d_state", i), res_q[tbl[i].dut], tbl[i].exp);
            chk64($sformatf("vec%0d_latency", i), 64'(lat_q[tbl[i].dut]), 64'(LAT[tbl[i].dut]));
        end

        // Round-2 constant shows up in word 23 of the ROUNDS=2 result.
        s = ref_f('0, 2, p23);
        chk64("round2_const_w23", so[5][64*23 +: 64], p23 ^ 64'hF612BD1B9CE55141);

        // Random states on all four ROUNDS=24 widths at once.
        for (int it = 0; it < 5; it++) begin
            s   = rand_state();
            pat = ref_f(s, 24, p23);
            run_jobs(6'h0F, s);
            for (int d = 0; d < 4; d++) begin
                chk_vec($sformatf("rand%0d_s%0d_state", it, d), res_q[d], pat);
                chk64($sformatf("rand%0d_s%0d_latency", it, d), 64'(lat_q[d]), 64'(LAT[d]));
            end
        end

        // Start held every cycle on S=8: three jobs, state_i churning.
        @(negedge clk);
        nacc = 0; ndone = 0; stable = 1'b1; prev = so[3]; k = 0;
        start[3] = 1'b1;
        while (ndone < 3 && k < 200) begin
            if (done[3]) begin
                if (ndone < nacc) begin
                    chk64($sformatf("b2b_job%0d_latency", ndone), 64'(k - acc_k[ndone]), 64'd24);
                    chk_vec($sformatf("b2b_job%0d_state", ndone), so[3], ref_f(acc_s[ndone], 24, p23));
                end
                ndone++;
            end else if (so[3] !== prev) begin
                stable = 1'b0;
            end
            prev = so[3];
            if (nacc == 3) start[3] = 1'b0;
            state_i = rand_state();
            if (start[3] && ready[3]) begin
                acc_k[nacc] = k + 1; acc_s[nacc] = state_i; nacc++;
            end
            @(negedge clk);
            k++;
        end
        start[3] = 1'b0;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done[3]) extra++;
        end
        chk64("b2b_done_count", 64'(ndone), 64'd3);
        chk64("b2b_accept_count", 64'(nacc), 64'd3);
        chk64("b2b_extra_done", 64'(extra), 64'd0);
        chk64("b2b_state_o_stable", 64'(stable), 64'd1);

        // Reset at RUN cycle 10 on S=2 with start held high.
        @(negedge clk);
        state_i = rand_state();
        start[1] = 1'b1;
        sawdone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done[1]) sawdone++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk64("rst_run_ready", 64'(ready[1]), 64'd1);
        chk64("rst_run_done", 64'(done[1]), 64'd0);
        chk_vec("rst_run_state_o", so[1], '0);
        rst = 1'b0;
        start[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done[1]) sawdone++;
        end
        chk64("rst_run_no_done", 64'(sawdone), 64'd0);
        s = rand_state();
        run_jobs(6'h02, s);
        chk_vec("post_rst_state", res_q[1], ref_f(s, 24, p23));
        chk64("post_rst_latency", 64'(lat_q[1]), 64'd96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
